// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and load/store requesters
// Optional feature: define MEM_PORT_ARB_TIMEOUT_EN to abort transactions that wait TIMEOUT cycles for mem_ack.
module mem_port_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 15
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            if_req,
  input  logic [AW-1:0]   if_addr,
  output logic [DW-1:0]   if_rdata,
  output logic            if_ack,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic [DW-1:0]   d_rdata,
  output logic            d_ack,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic [DW-1:0]   mem_rdata,
  input  logic            mem_ack,
  output logic            owner,
  output logic            bus_err
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [AW-1:0]     mem_addr_q, mem_addr_d;
  logic [DW-1:0]     mem_wdata_q, mem_wdata_d;
  logic [DW/8-1:0]   mem_be_q, mem_be_d;
  logic [DW-1:0]     if_rdata_q, if_rdata_d;
  logic [DW-1:0]     d_rdata_q, d_rdata_d;
  logic              if_ack_q, if_ack_d;
  logic              d_ack_q, d_ack_d;
  logic              owner_q, owner_d;

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT);

  logic [CW-1:0]     cnt_q, cnt_d;
  logic [CW-1:0]     cnt_inc;
  logic              bus_err_q, bus_err_d;
`else
  logic              unused_timeout;
  assign unused_timeout = (TIMEOUT != 0);
`endif

  // Next-state and registered-output computation for the IDLE/BUSY/RESP arbiter
  always_comb begin
    state_d     = state_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    if_rdata_d  = if_rdata_q;
    d_rdata_d   = d_rdata_q;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    owner_d     = owner_q;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
    cnt_d       = cnt_q;
    cnt_inc     = cnt_q + 1'b1;
    bus_err_d   = 1'b0;
`endif

    unique case (state_q)
      IDLE: begin
        // Data side has fixed priority; a losing fetch simply stays pending.
        if (d_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = d_we;
          mem_addr_d  = d_addr;
          mem_wdata_d = d_wdata;
          mem_be_d    = d_be;
          owner_d     = 1'b1;
          state_d     = BUSY;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end else if (if_req) begin
          mem_req_d   = 1'b1;
          mem_we_d    = 1'b0;
          mem_addr_d  = if_addr;
          mem_wdata_d = '0;
          mem_be_d    = {(DW/8){1'b1}};
          owner_d     = 1'b0;
          state_d     = BUSY;
`ifdef MEM_PORT_ARB_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end

      BUSY: begin
        // mem_ack wins over a timeout that would expire in the same cycle.
        if (mem_ack) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          if (owner_q) begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
        end
`ifdef MEM_PORT_ARB_TIMEOUT_EN
        else if (cnt_inc == TO_LIMIT) begin
          mem_req_d = 1'b0;
          state_d   = RESP;
          bus_err_d = 1'b1;
          if (owner_q) begin
            d_rdata_d = '0;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = '0;
            if_ack_d   = 1'b1;
          end
        end else begin
          cnt_d = cnt_inc;
        end
`endif
      end

      RESP: begin
        // Ack is high for this single cycle; requests are deliberately not sampled here.
        state_d = IDLE;
      end

      default: begin
        state_d   = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; reset drops any in-flight request without acking it
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_ack_q    <= 1'b0;
      d_ack_q     <= 1'b0;
      owner_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      if_rdata_q  <= if_rdata_d;
      d_rdata_q   <= d_rdata_d;
      if_ack_q    <= if_ack_d;
      d_ack_q     <= d_ack_d;
      owner_q     <= owner_d;
    end
  end

`ifdef MEM_PORT_ARB_TIMEOUT_EN
  // Wait-cycle counter and error pulse for the timeout path
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;
  assign if_ack    = if_ack_q;
  assign d_ack     = d_ack_q;
  assign owner     = owner_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - scoreboard bench for mem_port_arbiter
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;
  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic [31:0] d_rdata;
  logic        d_ack;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        owner;
  logic        bus_err;

  typedef struct {
    logic        dside;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t mem_q[$];
  exp_t resp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   last_busy = 0;
  int   first_c = -1;

  always #5 clk = ~clk;

  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .owner(owner), .bus_err(bus_err)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_data(input logic [31:0] a);
    if (a == 32'h100) return 32'h00500093;
    return (a * 32'd3) ^ 32'hA5A5_0000;
  endfunction

  task automatic push(input logic ds, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] be, input logic err);
    exp_t e;
    e.dside = ds; e.we = we; e.addr = addr; e.wdata = wdata; e.be = be; e.err = err;
    e.rdata = err ? 32'h0 : mem_data(addr);
    mem_q.push_back(e);
    resp_q.push_back(e);
  endtask

  // Acts as the memory (ack after wait_st wait states, or never) and scores acks
  task automatic run(input int wait_st, input bit ack_en, input int budget);
    exp_t m;
    exp_t r;
    int   busy;
    int   c;
    busy = 0;
    c = 0;
    first_c = -1;
    while (resp_q.size() > 0 && c < budget) begin
      @(posedge clk); #1;
      c++;
      if (mem_req) begin
        if (busy == 0) begin
          if (first_c < 0) first_c = c;
          if (mem_q.size() == 0) check("mem_unexpected", 64'(1), 64'(0));
          else begin
            m = mem_q.pop_front();
            check("mem_owner", 64'(owner), 64'(m.dside));
            check("mem_we", 64'(mem_we), 64'(m.we));
            check("mem_addr", 64'(mem_addr), 64'(m.addr));
            check("mem_be", 64'(mem_be), 64'(m.be));
            if (m.we) check("mem_wdata", 64'(mem_wdata), 64'(m.wdata));
          end
        end
        busy++;
      end else if (busy > 0) begin
        last_busy = busy;
        busy = 0;
      end
      if (if_ack || d_ack) begin
        r = resp_q.pop_front();
        check("ack_side", 64'(d_ack), 64'(r.dside));
        check("ack_both", 64'(if_ack & d_ack), 64'(0));
        check("rdata", 64'(r.dside ? d_rdata : if_rdata), 64'(r.rdata));
        check("bus_err", 64'(bus_err), 64'(r.err));
        if (d_ack) d_req = 1'b0;
        else if_req = 1'b0;
      end
      mem_ack   = ack_en && mem_req && (busy == wait_st + 1);
      mem_rdata = mem_ack ? mem_data(mem_addr) : 32'h0;
    end
    if (resp_q.size() != 0) begin
      check("resp_budget", 64'(resp_q.size()), 64'(0));
      resp_q.delete();
      mem_q.delete();
      if_req = 1'b0;
      d_req  = 1'b0;
    end
    mem_ack = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("no_extra_ack", 64'({if_ack, d_ack, bus_err}), 64'(0));
    end
  endtask

  initial begin
    reset = 1'b1;
    if_req = 1'b0; if_addr = '0; d_req = 1'b0; d_we = 1'b0; d_addr = '0;
    d_wdata = '0; d_be = '0; mem_rdata = '0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ctl", 64'({mem_req, mem_we, mem_be, if_ack, d_ack, owner, bus_err}), 64'(0));
    check("rst_addr", 64'(mem_addr), 64'(0));
    check("rst_wdata", 64'(mem_wdata), 64'(0));
    check("rst_rdata", 64'({if_rdata, d_rdata}), 64'(0));
    reset = 1'b0;
    @(posedge clk); #1;

    // single fetch, zero-wait memory
    if_req = 1'b1; if_addr = 32'h100;
    push(1'b0, 1'b0, 32'h100, 32'h0, 4'hF, 1'b0);
    run(0, 1'b1, 20);
    check("fetch_latency", 64'(first_c), 64'(1));
    check("fetch_busy", 64'(last_busy), 64'(1));
    check("fetch_owner", 64'(owner), 64'(0));

    // store with two wait states
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hCAFEF00D; d_be = 4'h3;
    push(1'b1, 1'b1, 32'h2000, 32'hCAFEF00D, 4'h3, 1'b0);
    run(2, 1'b1, 20);
    check("store_busy", 64'(last_busy), 64'(3));

    // contention: data first, then the pending fetch
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
    if_req = 1'b1; if_addr = 32'h104;
    push(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0);
    push(1'b0, 1'b0, 32'h104, 32'h0, 4'hF, 1'b0);
    run(1, 1'b1, 40);
    check("d_rdata_hold", 64'(d_rdata), 64'(mem_data(32'h40)));

    // stray mem_ack while idle
    mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("stray_req", 64'(mem_req), 64'(0));
      check("stray_ack", 64'({if_ack, d_ack}), 64'(0));
    end
    check("stray_rdata", 64'(if_rdata), 64'(mem_data(32'h104)));
    mem_ack = 1'b0; mem_rdata = '0;

    // asynchronous reset in the middle of a transaction
    if_req = 1'b1; if_addr = 32'h200;
    @(posedge clk); #1;
    check("pre_rst_req", 64'(mem_req), 64'(1));
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("rst_mid_ctl", 64'({mem_req, mem_we, mem_be, if_ack, d_ack, owner, bus_err}), 64'(0));
    check("rst_mid_addr", 64'(mem_addr), 64'(0));
    check("rst_mid_rdata", 64'({if_rdata, d_rdata}), 64'(0));
    if_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_idle", 64'({mem_req, if_ack, d_ack}), 64'(0));
    if_req = 1'b1; if_addr = 32'h108;
    push(1'b0, 1'b0, 32'h108, 32'h0, 4'hF, 1'b0);
    run(1, 1'b1, 20);

`ifdef MEM_PORT_ARB_TIMEOUT_EN
    // memory never answers: timeout after four BUSY cycles
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
    push(1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b1);
    run(0, 1'b0, 20);
    check("to_busy", 64'(last_busy), 64'(4));
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      check("late_ack", 64'({mem_req, d_ack, if_ack, bus_err}), 64'(0));
    end
    check("late_rdata", 64'(d_rdata), 64'(0));
    mem_ack = 1'b0; mem_rdata = '0;
    // ack in the same cycle the count reaches the limit is a success
    d_req = 1'b1; d_addr = 32'h3004;
    push(1'b1, 1'b0, 32'h3004, 32'h0, 4'hF, 1'b0);
    run(3, 1'b1, 20);
    check("edge_busy", 64'(last_busy), 64'(4));
`else
    // without the timeout the port waits as long as memory needs
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'hF;
    push(1'b1, 1'b0, 32'h3000, 32'h0, 4'hF, 1'b0);
    run(6, 1'b1, 30);
    check("long_busy", 64'(last_busy), 64'(7));
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
